// File: rtl/mmind_pkg.sv
// Shared constants and state encodings for the mastermind game sequencer.
package mmind_pkg;
  localparam int NPEG        = 4;
  localparam int CW          = 2;
  localparam int MAX_GUESSES = 8;
  localparam int SW_W        = NPEG * CW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GUESS = 3'd1,
    S_EXACT = 3'd2,
    S_COLOR = 3'd3,
    S_DONE  = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_e;
endpackage

// File: rtl/mmind_ctrl_if.sv
// Button/switch inputs and score/display outputs of the game sequencer.
interface mmind_ctrl_if;
  import mmind_pkg::*;

  logic            setans_btn;
  logic            guess_btn;
  logic [SW_W-1:0] switches;
  logic [2:0]      black;
  logic [2:0]      white;
  logic [3:0]      guess_cnt;
  logic            score_valid;
  logic            win;
  logic            lose;
  logic [2:0]      state_o;

  modport master (
    output setans_btn, guess_btn, switches,
    input  black, white, guess_cnt, score_valid, win, lose, state_o
  );

  modport slave (
    input  setans_btn, guess_btn, switches,
    output black, white, guess_cnt, score_valid, win, lose, state_o
  );
endinterface

// File: rtl/mmind_edge.sv
// Rising-edge detector: pulse in the cycle the input is first seen high after low.
// Zero latency (combinational on the current sample); no backpressure.
module mmind_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;
endmodule

// File: rtl/mmind_ctrl.sv
// Mastermind sequencer: latch answer/guess, score serially, track guesses, declare win/lose.
// Score 9 cycles after the guess edge; buttons during scoring are dropped, not queued.
module mmind_ctrl
  import mmind_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mmind_ctrl_if.slave  bus
);
  localparam logic [2:0] FULL_B  = 3'(NPEG);
  localparam logic [3:0] MAX_CNT = 4'(MAX_GUESSES);

  state_e          state_q, state_d;
  logic [SW_W-1:0] ans_q, ans_d, gss_q, gss_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0]      acc_b_q, acc_b_d, acc_c_q, acc_c_d;
  logic [2:0]      black_q, black_d, white_q, white_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            sv_q, sv_d, win_q, win_d, lose_q, lose_d;
  logic            set_rise, guess_rise;
  logic [2:0]      n_ans, n_gss, n_min;

  mmind_edge u_set_edge (.clk(clk), .reset(reset), .btn_i(bus.setans_btn), .rise_o(set_rise));
  mmind_edge u_gss_edge (.clk(clk), .reset(reset), .btn_i(bus.guess_btn),  .rise_o(guess_rise));

  function automatic logic [2:0] col_cnt(input logic [SW_W-1:0] code, input logic [CW-1:0] c);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NPEG; i++) begin
      if (code[i*CW +: CW] == c) n = n + 3'd1;
    end
    return n;
  endfunction

  // idx doubles as peg index in S_EXACT and colour value in S_COLOR
  assign n_ans = col_cnt(ans_q, idx_q);
  assign n_gss = col_cnt(gss_q, idx_q);
  assign n_min = (n_ans < n_gss) ? n_ans : n_gss;

  always_comb begin
    state_d = state_q;
    ans_d   = ans_q;
    gss_d   = gss_q;
    idx_d   = idx_q;
    acc_b_d = acc_b_q;
    acc_c_d = acc_c_q;
    black_d = black_q;
    white_d = white_q;
    cnt_d   = cnt_q;
    sv_d    = 1'b0;
    win_d   = win_q;
    lose_d  = lose_q;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (set_rise) begin
          ans_d   = bus.switches;
          cnt_d   = '0;
          black_d = '0;
          white_d = '0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          state_d = S_GUESS;
        end
      end
      S_GUESS: begin
        if (guess_rise) begin
          gss_d   = bus.switches;
          cnt_d   = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 4'd1;
          idx_d   = '0;
          acc_b_d = '0;
          acc_c_d = '0;
          state_d = S_EXACT;
        end
      end
      S_EXACT: begin
        if (ans_q[int'(idx_q)*CW +: CW] == gss_q[int'(idx_q)*CW +: CW]) acc_b_d = acc_b_q + 3'd1;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_COLOR;
      end
      S_COLOR: begin
        acc_c_d = acc_c_q + n_min;
        idx_d   = idx_q + 2'd1;
        // Publish on the last colour so the pulse and new score coincide in S_DONE
        if (idx_q == 2'd3) begin
          black_d = acc_b_q;
          white_d = acc_c_d - acc_b_q;
          sv_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (black_q == FULL_B) begin
          win_d   = 1'b1;
          state_d = S_WIN;
        end else if (cnt_q == MAX_CNT) begin
          lose_d  = 1'b1;
          state_d = S_LOSE;
        end else begin
          state_d = S_GUESS;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ans_q   <= '0;
      gss_q   <= '0;
      idx_q   <= '0;
      acc_b_q <= '0;
      acc_c_q <= '0;
      black_q <= '0;
      white_q <= '0;
      cnt_q   <= '0;
      sv_q    <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ans_q   <= ans_d;
      gss_q   <= gss_d;
      idx_q   <= idx_d;
      acc_b_q <= acc_b_d;
      acc_c_q <= acc_c_d;
      black_q <= black_d;
      white_q <= white_d;
      cnt_q   <= cnt_d;
      sv_q    <= sv_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign bus.black       = black_q;
  assign bus.white       = white_q;
  assign bus.guess_cnt   = cnt_q;
  assign bus.score_valid = sv_q;
  assign bus.win         = win_q;
  assign bus.lose        = lose_q;
  assign bus.state_o     = state_q;
endmodule

// File: tb/tb_mmind_ctrl.sv
// Directed, table-driven bench for the mastermind sequencer plus hand-written corner sequences.
module tb_mmind_ctrl;
  import mmind_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mmind_ctrl_if bus ();
  mmind_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  typedef enum int {K_SET, K_GUESS, K_IGN} kind_e;
  typedef struct {
    kind_e      kind;
    logic       use_set;
    logic [7:0] sw;
    logic [2:0] b;
    logic [2:0] w;
    logic [3:0] cnt;
    logic [2:0] st;
    logic       win;
    logic       lose;
  } vec_t;

  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(kind_e k, logic s, logic [7:0] sw, logic [2:0] b, logic [2:0] w,
                              logic [3:0] cnt, logic [2:0] st, logic win, logic lose);
    vec_t v;
    v.kind = k; v.use_set = s; v.sw = sw; v.b = b; v.w = w;
    v.cnt = cnt; v.st = st; v.win = win; v.lose = lose;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic sv_early, sv_seen;

    // answer c3 = pegs 3,0,0,3
    tbl.push_back(mk(K_SET,   1, 8'hc3, 0, 0, 0, S_GUESS, 0, 0));
    tbl.push_back(mk(K_GUESS, 0, 8'hff, 2, 0, 1, S_GUESS, 0, 0));
    tbl.push_back(mk(K_GUESS, 0, 8'h3c, 0, 4, 2, S_GUESS, 0, 0));
    tbl.push_back(mk(K_GUESS, 0, 8'hc3, 4, 0, 3, S_WIN,   1, 0));
    tbl.push_back(mk(K_IGN,   0, 8'h00, 4, 0, 3, S_WIN,   1, 0));
    tbl.push_back(mk(K_SET,   1, 8'hff, 0, 0, 0, S_GUESS, 0, 0));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(K_GUESS, 0, 8'h00, 0, 0, 4'(i), (i == 8) ? S_LOSE : S_GUESS, 0, (i == 8)));
    tbl.push_back(mk(K_IGN,   0, 8'h00, 0, 0, 8, S_LOSE,  0, 1));
    // answer 1b = pegs 3,2,1,0
    tbl.push_back(mk(K_SET,   1, 8'h1b, 0, 0, 0, S_GUESS, 0, 0));
    tbl.push_back(mk(K_IGN,   1, 8'hff, 0, 0, 0, S_GUESS, 0, 0));
    tbl.push_back(mk(K_GUESS, 0, 8'he4, 0, 4, 1, S_GUESS, 0, 0));
    tbl.push_back(mk(K_GUESS, 0, 8'h1e, 2, 2, 2, S_GUESS, 0, 0));

    bus.setans_btn = 1'b0;
    bus.guess_btn  = 1'b0;
    bus.switches   = '0;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state_o), 32'(S_IDLE));
    chk("rst_black", 32'(bus.black), 0);
    chk("rst_white", 32'(bus.white), 0);
    chk("rst_cnt",   32'(bus.guess_cnt), 0);
    chk("rst_sv",    32'(bus.score_valid), 0);
    chk("rst_win",   32'(bus.win), 0);
    chk("rst_lose",  32'(bus.lose), 0);
    @(negedge clk) reset = 1'b0;

    foreach (tbl[r]) begin
      v = tbl[r];
      @(negedge clk);
      bus.switches = v.sw;
      if (v.use_set) bus.setans_btn = 1'b1;
      else           bus.guess_btn  = 1'b1;
      case (v.kind)
        K_SET: begin
          @(posedge clk); #1;
          chk($sformatf("set%0d_state", r), 32'(bus.state_o), 32'(v.st));
          chk($sformatf("set%0d_cnt", r),   32'(bus.guess_cnt), 32'(v.cnt));
          chk($sformatf("set%0d_winlose", r), {30'd0, bus.win, bus.lose}, {30'd0, v.win, v.lose});
          chk($sformatf("set%0d_bw", r), {26'd0, bus.black, bus.white}, {26'd0, v.b, v.w});
        end
        K_GUESS: begin
          sv_early = 1'b0;
          for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 0) chk($sformatf("g%0d_lat_exact", r), 32'(bus.state_o), 32'(S_EXACT));
            if (k == 4) chk($sformatf("g%0d_lat_color", r), 32'(bus.state_o), 32'(S_COLOR));
            if (k < 8) sv_early |= bus.score_valid;
          end
          chk($sformatf("g%0d_sv_early", r), 32'(sv_early), 0);
          chk($sformatf("g%0d_sv", r),    32'(bus.score_valid), 1);
          chk($sformatf("g%0d_black", r), 32'(bus.black), 32'(v.b));
          chk($sformatf("g%0d_white", r), 32'(bus.white), 32'(v.w));
          chk($sformatf("g%0d_cnt", r),   32'(bus.guess_cnt), 32'(v.cnt));
          @(negedge clk) bus.guess_btn = 1'b0;
          @(posedge clk); #1;
          chk($sformatf("g%0d_sv_pulse", r), 32'(bus.score_valid), 0);
          chk($sformatf("g%0d_state", r), 32'(bus.state_o), 32'(v.st));
          chk($sformatf("g%0d_winlose", r), {30'd0, bus.win, bus.lose}, {30'd0, v.win, v.lose});
        end
        default: begin
          sv_seen = 1'b0;
          repeat (12) begin
            @(posedge clk); #1;
            sv_seen |= bus.score_valid;
          end
          chk($sformatf("ign%0d_sv", r),    32'(sv_seen), 0);
          chk($sformatf("ign%0d_state", r), 32'(bus.state_o), 32'(v.st));
          chk($sformatf("ign%0d_cnt", r),   32'(bus.guess_cnt), 32'(v.cnt));
          chk($sformatf("ign%0d_bw", r), {26'd0, bus.black, bus.white}, {26'd0, v.b, v.w});
          chk($sformatf("ign%0d_winlose", r), {30'd0, bus.win, bus.lose}, {30'd0, v.win, v.lose});
        end
      endcase
      @(negedge clk);
      bus.setans_btn = 1'b0;
      bus.guess_btn  = 1'b0;
    end

    // Re-press during S_EXACT, hold through S_DONE, switches changed mid-score
    @(negedge clk);
    bus.switches  = 8'he4;
    bus.guess_btn = 1'b1;
    sv_early = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k < 8) sv_early |= bus.score_valid;
      if (k == 1) begin @(negedge clk); bus.guess_btn = 1'b0; end
      if (k == 2) begin @(negedge clk); bus.guess_btn = 1'b1; bus.switches = 8'h00; end
    end
    chk("hold_sv_early", 32'(sv_early), 0);
    chk("hold_sv",       32'(bus.score_valid), 1);
    chk("hold_black",    32'(bus.black), 0);
    chk("hold_white",    32'(bus.white), 4);
    chk("hold_cnt",      32'(bus.guess_cnt), 3);
    sv_seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      sv_seen |= bus.score_valid;
    end
    chk("hold_no_rescore", 32'(sv_seen), 0);
    chk("hold_cnt_after",  32'(bus.guess_cnt), 3);
    chk("hold_state",      32'(bus.state_o), 32'(S_GUESS));
    @(negedge clk) bus.guess_btn = 1'b0;

    // Reset sampled at T+3 of scoring aborts it
    @(negedge clk);
    bus.switches  = 8'he4;
    bus.guess_btn = 1'b1;
    @(posedge clk);
    @(negedge clk) bus.guess_btn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", 32'(bus.state_o), 32'(S_IDLE));
    chk("abort_bw",    {26'd0, bus.black, bus.white}, 0);
    chk("abort_cnt",   32'(bus.guess_cnt), 0);
    chk("abort_flags", {29'd0, bus.score_valid, bus.win, bus.lose}, 0);
    @(negedge clk) reset = 1'b0;
    sv_seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      sv_seen |= bus.score_valid;
    end
    chk("abort_no_sv", 32'(sv_seen), 0);
    chk("abort_idle",  32'(bus.state_o), 32'(S_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
